wb_retire: RTL and testbench

//   Writeback/retire stage at the tail of the pipeline, fed by the memory stage.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/st_tracker.sv | 57 +++++
 rtl/wb_retire.sv | 123 ++++++++++++
 tb/tb_wb_retire.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the writeback/retire slice.
// Holds the retire-state encoding and default widths.
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } retire_state_e;

    localparam int DATA_W_D    = 16;
    localparam int REG_AW_D    = 4;
    localparam int MAX_OUTST_D = 4;

endpackage

// File: rtl/st_tracker.sv
// Outstanding-store tracker: saturating up/down counter of un-acked stores.
// Ports: i_inc (store accepted), i_dec (st_ack), o_cnt, o_full,
//        o_zero_nxt (count is zero after this edge), o_err (sticky underflow).
module st_tracker
#(
    parameter int MAX = 4,
    parameter int OW  = $clog2(MAX + 1)
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [OW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_zero_nxt,
    output logic          o_err
);

    localparam logic [OW-1:0] MAXC = OW'(MAX);

    logic [OW-1:0] r_cnt;
    logic [OW-1:0] w_cnt_nxt;
    logic          r_err;
    logic          w_under;

    // An ack with nothing outstanding is an underflow unless a new store
    // arrives in the same cycle to cover it.
    assign w_under = i_dec && !i_inc && (r_cnt == '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_inc && !i_dec && (r_cnt != MAXC)) begin
            w_cnt_nxt = r_cnt + OW'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            w_cnt_nxt = r_cnt - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_under) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_cnt      = r_cnt;
    assign o_full     = (r_cnt == MAXC);
    assign o_zero_nxt = (w_cnt_nxt == '0);
    assign o_err      = r_err;

endmodule

// File: rtl/wb_retire.sv
// Writeback/retire stage: registers retiring instructions, drives the
// regfile write port / bypass, and holds isHalt until stores have drained.
// Ports: m_* handshake from memory stage, st_ack, rf_*/fwd_* write+bypass,
//        W_v retire pulse, isHalt, outst count, sticky ack_err.
module wb_retire
    import pipe_pkg::*;
#(
    parameter int DATA_W    = DATA_W_D,
    parameter int REG_AW    = REG_AW_D,
    parameter int MAX_OUTST = MAX_OUTST_D,
    parameter int OW        = $clog2(MAX_OUTST + 1)
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_v,
    output logic              m_ready,
    input  logic              m_halt,
    input  logic              m_wen,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [DATA_W-1:0] m_data,
    input  logic              m_st,
    input  logic              st_ack,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              fwd_v,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic              W_v,
    output logic              isHalt,
    output logic [OW-1:0]     outst,
    output logic              ack_err
);

    retire_state_e     r_state;
    retire_state_e     w_state_nxt;
    logic              w_full;
    logic              w_zero_nxt;
    logic              w_acc;
    logic              w_wr;
    logic              r_wv;
    logic              r_wen;
    logic [REG_AW-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    // rst_n gating keeps m_ready low while reset is held.
    assign m_ready = rst_n && (r_state == RUN) && !w_full;
    assign w_acc   = m_v && m_ready;
    // HALT retires without writing, even if m_wen is set.
    assign w_wr    = w_acc && m_wen && !m_halt;

    st_tracker #(
        .MAX (MAX_OUTST),
        .OW  (OW)
    ) u_st (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_acc && m_st),
        .i_dec      (st_ack),
        .o_cnt      (outst),
        .o_full     (w_full),
        .o_zero_nxt (w_zero_nxt),
        .o_err      (ack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wv    <= 1'b0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wv  <= w_acc;
            r_wen <= w_wr;
            if (w_wr) begin
                r_waddr <= m_rd;
                r_wdata <= m_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (w_acc && m_halt) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Uses the post-update count so the final ack halts at once.
                if (w_zero_nxt) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign W_v      = r_wv;
    assign rf_wen   = r_wen;
    assign rf_waddr = r_waddr;
    assign rf_wdata = r_wdata;
    assign fwd_v    = r_wen;
    assign fwd_rd   = r_waddr;
    assign fwd_data = r_wdata;
    assign isHalt   = (r_state == HALTED);

endmodule

// File: tb/tb_wb_retire.sv
// Self-checking bench for wb_retire: directed scenarios plus random traffic
// compared every cycle against a behavioural retire/store-count model.
module tb_wb_retire;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int MX = 4;
    localparam int OW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m_v = 1'b0;
    logic          m_ready;
    logic          m_halt = 1'b0;
    logic          m_wen = 1'b0;
    logic [AW-1:0] m_rd = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_st = 1'b0;
    logic          st_ack = 1'b0;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fwd_v;
    logic [AW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
    logic          W_v;
    logic          isHalt;
    logic [OW-1:0] outst;
    logic          ack_err;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model state
    bit        e_wv, e_wen, e_err, e_halt_seen, e_halted;
    int        e_outst;
    int        e_addr, e_data;

    wb_retire dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m_v      (m_v),
        .m_ready  (m_ready),
        .m_halt   (m_halt),
        .m_wen    (m_wen),
        .m_rd     (m_rd),
        .m_data   (m_data),
        .m_st     (m_st),
        .st_ack   (st_ack),
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .fwd_v    (fwd_v),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .W_v      (W_v),
        .isHalt   (isHalt),
        .outst    (outst),
        .ack_err  (ack_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit e_ready();
        return rst_n && !e_halt_seen && (e_outst < MX);
    endfunction

    task automatic model_reset();
        e_wv = 0; e_wen = 0; e_err = 0;
        e_halt_seen = 0; e_halted = 0;
        e_outst = 0; e_addr = 0; e_data = 0;
    endtask

    // One clock edge of the retire behaviour, from the inputs at that edge.
    task automatic model_step();
        bit acc, st_in, draining;
        int n;
        acc      = m_v && e_ready();
        st_in    = acc && m_st;
        draining = e_halt_seen && !e_halted;
        e_wv  = acc;
        e_wen = acc && m_wen && !m_halt;
        if (e_wen) begin
            e_addr = int'(m_rd);
            e_data = int'(m_data);
        end
        if (st_ack && !st_in && e_outst == 0) e_err = 1;
        n = e_outst + int'(st_in) - int'(st_ack);
        e_outst = (n < 0) ? 0 : n;
        if (draining && e_outst == 0) e_halted = 1;
        if (acc && m_halt) e_halt_seen = 1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_ready", 32'(m_ready), 32'(e_ready()));
            chk("W_v", 32'(W_v), 32'(e_wv));
            chk("rf_wen", 32'(rf_wen), 32'(e_wen));
            chk("fwd_v", 32'(fwd_v), 32'(e_wen));
            chk("isHalt", 32'(isHalt), 32'(e_halted));
            chk("outst", 32'(outst), 32'(e_outst));
            chk("ack_err", 32'(ack_err), 32'(e_err));
            if (e_wen) begin
                chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
                chk("rf_wdata", 32'(rf_wdata), 32'(e_data));
                chk("fwd_rd", 32'(fwd_rd), 32'(e_addr));
                chk("fwd_data", 32'(fwd_data), 32'(e_data));
            end
        end
    end

    task automatic drive(input bit v, input bit h, input bit w,
                         input int rd, input int d, input bit s, input bit a);
        m_v = v; m_halt = h; m_wen = w;
        m_rd = AW'(rd); m_data = DW'(d);
        m_st = s; st_ack = a;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Advance one edge; inputs are changed 2 time units after the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        chk_on = 1'b1;
        step();
        #1;
        chk("rst W_v", 32'(W_v), 0);
        chk("rst m_ready", 32'(m_ready), 0);
        chk("rst rf_waddr", 32'(rf_waddr), 0);
        chk("rst rf_wdata", 32'(rf_wdata), 0);
        do_reset();

        // 1: single ADD
        drive(1, 0, 1, 3, 'h1234, 0, 0);
        step();
        chk("t1 W_v", 32'(W_v), 1);
        chk("t1 rf_wen", 32'(rf_wen), 1);
        chk("t1 rf_waddr", 32'(rf_waddr), 3);
        chk("t1 rf_wdata", 32'(rf_wdata), 'h1234);
        idle();
        step();
        chk("t1 W_v off", 32'(W_v), 0);

        // 2: five back-to-back
        for (int i = 0; i < 5; i++) begin
            chk("t2 m_ready", 32'(m_ready), 1);
            drive(1, 0, 1, i + 1, 'h100 + i, 0, 0);
            step();
            chk("t2 W_v", 32'(W_v), 1);
            chk("t2 rf_waddr", 32'(rf_waddr), 32'(i + 1));
        end
        idle();
        step();

        // 3: HALT with no stores
        drive(1, 1, 1, 7, 'hdead, 0, 0);
        step();
        chk("t3 W_v", 32'(W_v), 1);
        chk("t3 rf_wen", 32'(rf_wen), 0);
        chk("t3 m_ready", 32'(m_ready), 0);
        chk("t3 isHalt early", 32'(isHalt), 0);
        drive(1, 0, 1, 2, 'h55, 0, 0);
        step();
        chk("t3 isHalt", 32'(isHalt), 1);
        step();
        chk("t3 W_v ignored", 32'(W_v), 0);
        do_reset();

        // 4: two stores then HALT, two acks
        drive(1, 0, 0, 0, 0, 1, 0); step();
        chk("t4 outst1", 32'(outst), 1);
        drive(1, 0, 0, 0, 0, 1, 0); step();
        chk("t4 outst2", 32'(outst), 2);
        drive(1, 1, 0, 0, 0, 0, 0); step();
        idle(); step(); step();
        drive(0, 0, 0, 0, 0, 0, 1); step();
        chk("t4 outst after ack", 32'(outst), 1);
        chk("t4 still draining", 32'(isHalt), 0);
        idle(); step(); step(); step();
        drive(0, 0, 0, 0, 0, 0, 1); step();
        chk("t4 outst0", 32'(outst), 0);
        chk("t4 isHalt", 32'(isHalt), 1);
        idle(); step();
        do_reset();

        // 5: fill, simultaneous store+ack, underflow
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 1, 0); step();
        end
        chk("t5 full", 32'(outst), 4);
        chk("t5 m_ready", 32'(m_ready), 0);
        drive(0, 0, 0, 0, 0, 0, 1); step();
        drive(1, 0, 0, 0, 0, 1, 1); step();
        chk("t5 st+ack", 32'(outst), 3);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1); step();
        end
        chk("t5 drained", 32'(outst), 0);
        chk("t5 no err", 32'(ack_err), 0);
        drive(0, 0, 0, 0, 0, 0, 1); step();
        chk("t5 ack_err", 32'(ack_err), 1);
        chk("t5 outst stays 0", 32'(outst), 0);
        idle(); step();

        // 6: async reset in DRAIN with outst=2
        do_reset();
        drive(1, 0, 1, 5, 'hbeef, 1, 0); step();
        drive(1, 0, 0, 0, 0, 1, 0); step();
        drive(1, 1, 0, 0, 0, 0, 0); step();
        idle();
        chk("t6 pre outst", 32'(outst), 2);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6 async W_v", 32'(W_v), 0);
        chk("t6 async outst", 32'(outst), 0);
        chk("t6 async rf_wdata", 32'(rf_wdata), 0);
        chk("t6 async m_ready", 32'(m_ready), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("t6 m_ready", 32'(m_ready), 1);
        chk("t6 isHalt", 32'(isHalt), 0);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            bit v, h, s, a;
            v = ($urandom_range(0, 9) < 7);
            h = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 9) < 3);
            a = (e_outst > 0) && ($urandom_range(0, 9) < 3);
            drive(v, h, $urandom_range(0, 1), $urandom_range(0, 15),
                  $urandom_range(0, 'hffff), s, a);
            step();
            if ((e_halted && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 299) == 0) begin
                do_reset();
            end
        end
        idle();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
